// File: rtl/sc_dmem_arbiter_if.sv
// rtl/sc_dmem_arbiter_if.sv - one requester port of the data-memory arbiter
// master = requester (CPU or DMA), slave = arbiter.
interface sc_dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rdata
    );
endinterface

// File: rtl/sc_dmem_arbiter.sv
// rtl/sc_dmem_arbiter.sv - round-robin arbiter with bus lock and starvation guard
// Shares one async-read data memory between port 0 (CPU) and port 1 (DMA/debug).
module sc_dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              clr,
    sc_dmem_arbiter_if.slave  p0,
    sc_dmem_arbiter_if.slave  p1,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_datain,
    output logic              mem_we,
    input  logic [DW-1:0]     mem_dataout,
    output logic [1:0]        owner
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        NONE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } own_t;

    own_t          state;
    logic          ptr;
    logic [WW-1:0] wait0;
    logic [WW-1:0] wait1;
    logic          g0;
    logic          g1;
    logic          brk;

    // Starvation break outranks the lock; a released owner falls back to round-robin.
    always_comb begin
        g0  = 1'b0;
        g1  = 1'b0;
        brk = 1'b0;
        if (!clr) begin
            if (state == OWN0 && p1.req && wait1 == WMAX) begin
                g1  = 1'b1;
                brk = 1'b1;
            end else if (state == OWN1 && p0.req && wait0 == WMAX) begin
                g0  = 1'b1;
                brk = 1'b1;
            end else if (state == OWN0 && p0.req) begin
                g0 = 1'b1;
            end else if (state == OWN1 && p1.req) begin
                g1 = 1'b1;
            end else if (p0.req && p1.req) begin
                g0 = ~ptr;
                g1 = ptr;
            end else begin
                g0 = p0.req;
                g1 = p1.req;
            end
        end
    end

    always_comb begin
        mem_addr   = '0;
        mem_datain = '0;
        if (g1) begin
            mem_addr   = p1.addr;
            mem_datain = p1.wdata;
        end else if (!clr) begin
            mem_addr   = p0.addr;
            mem_datain = p0.wdata;
        end
    end

    assign mem_we   = (g0 & p0.we) | (g1 & p1.we);
    assign p0.gnt   = g0;
    assign p1.gnt   = g1;
    assign p0.rdata = mem_dataout;
    assign p1.rdata = mem_dataout;
    assign owner    = state;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= NONE;
            ptr   <= 1'b0;
            wait0 <= '0;
            wait1 <= '0;
        end else begin
            // A starvation winner never inherits ownership, so the old owner re-arbitrates.
            if (g0) begin
                ptr   <= 1'b1;
                state <= (p0.lock && !brk) ? OWN0 : NONE;
            end else if (g1) begin
                ptr   <= 1'b0;
                state <= (p1.lock && !brk) ? OWN1 : NONE;
            end else begin
                state <= NONE;
            end

            if (p0.req && !g0)
                wait0 <= (wait0 == WMAX) ? wait0 : wait0 + 1'b1;
            else
                wait0 <= '0;

            if (p1.req && !g1)
                wait1 <= (wait1 == WMAX) ? wait1 : wait1 + 1'b1;
            else
                wait1 <= '0;
        end
    end
endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// tb/tb_sc_dmem_arbiter.sv - scoreboard testbench for sc_dmem_arbiter
module tb_sc_dmem_arbiter;
    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_we;
    logic [31:0] mem_dataout;
    logic [1:0]  owner;

    sc_dmem_arbiter_if #(.AW(32), .DW(32)) p0_if ();
    sc_dmem_arbiter_if #(.AW(32), .DW(32)) p1_if ();

    sc_dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(8)) dut (
        .clk         (clk),
        .clr         (clr),
        .p0          (p0_if.slave),
        .p1          (p1_if.slave),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_we      (mem_we),
        .mem_dataout (mem_dataout),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    assign mem_dataout = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_datain;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_acc(input bit port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit c, input logic [31:0] rd);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.chk = c; e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic drive0(input bit req, input bit we, input bit lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
        p0_if.req = req; p0_if.we = we; p0_if.lock = lock; p0_if.addr = addr; p0_if.wdata = wdata;
    endtask

    task automatic drive1(input bit req, input bit we, input bit lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
        p1_if.req = req; p1_if.we = we; p1_if.lock = lock; p1_if.addr = addr; p1_if.wdata = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every grant seen away from the edge must match the scoreboard head.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!clr) begin
            if (p0_if.gnt && p1_if.gnt) begin
                chk("gnt_onehot", 32'd1, 32'd0);
            end else if (p0_if.gnt || p1_if.gnt) begin
                if (sb.size() == 0) begin
                    chk("unexpected_gnt", {31'd0, p1_if.gnt}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    chk("gnt_port", {31'd0, p1_if.gnt}, {31'd0, mon_e.port});
                    chk("mem_we", {31'd0, mem_we}, {31'd0, mon_e.we});
                    chk("mem_addr", mem_addr, mon_e.addr);
                    if (mon_e.we) chk("mem_datain", mem_datain, mon_e.wdata);
                    if (mon_e.chk) chk("rdata", mon_e.port ? p1_if.rdata : p0_if.rdata, mon_e.rdata);
                end
            end else begin
                chk("idle_we", {31'd0, mem_we}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, sb size %0d expected 0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        clr = 1'b1;
        drive0(1, 1, 0, 32'h4, 32'h77);
        drive1(1, 1, 0, 32'h8, 32'h66);
        #2;
        // 1: reset behaviour
        chk("rst_p0_gnt", {31'd0, p0_if.gnt}, 32'd0);
        chk("rst_p1_gnt", {31'd0, p1_if.gnt}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        tick();
        clr = 1'b0;
        drive0(1, 0, 1, 32'h0, 32'h0);
        expect_acc(0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        chk("own_p0_lock", {30'd0, owner}, 32'd1);
        clr = 1'b1;
        #1;
        chk("midrst_p0_gnt", {31'd0, p0_if.gnt}, 32'd0);
        chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("midrst_owner", {30'd0, owner}, 32'd0);
        drive0(0, 0, 0, 0, 0);
        tick();
        clr = 1'b0;
        chk("rst_ptr", {31'd0, dut.ptr}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd0);

        // 2: alternation p0,p1,p0,p1
        drive0(1, 1, 0, 32'h10, 32'hAA);
        drive1(1, 0, 0, 32'h10, 32'h0);
        expect_acc(0, 1, 32'h10, 32'hAA, 0, 0);
        tick();
        drive0(1, 1, 0, 32'h14, 32'h55);
        expect_acc(1, 0, 32'h10, 0, 1, 32'hAA);
        tick();
        drive1(1, 0, 0, 32'h14, 32'h0);
        expect_acc(0, 1, 32'h14, 32'h55, 0, 0);
        tick();
        drive0(0, 0, 0, 0, 0);
        expect_acc(1, 0, 32'h14, 0, 1, 32'h55);
        tick();
        drive1(0, 0, 0, 0, 0);

        // 5: single requester back-to-back stores
        for (int i = 0; i < 5; i++) begin
            drive0(1, 1, 0, 32'h40 + 32'(4 * i), 32'(i + 1));
            expect_acc(0, 1, 32'h40 + 32'(4 * i), 32'(i + 1), 0, 0);
            tick();
        end
        drive0(0, 0, 0, 0, 0);
        tick();

        // 3: p1 locked 3-word burst while p0 waits
        drive0(1, 0, 0, 32'h14, 0);
        drive1(1, 1, 1, 32'h20, 32'hA1);
        expect_acc(1, 1, 32'h20, 32'hA1, 0, 0);
        tick();
        chk("burst_owner1", {30'd0, owner}, 32'd2);
        chk("burst_wait1", 32'(dut.wait0), 32'd1);
        drive1(1, 1, 1, 32'h24, 32'hA2);
        expect_acc(1, 1, 32'h24, 32'hA2, 0, 0);
        tick();
        chk("burst_owner2", {30'd0, owner}, 32'd2);
        chk("burst_wait2", 32'(dut.wait0), 32'd2);
        drive1(1, 1, 0, 32'h28, 32'hA3);
        expect_acc(1, 1, 32'h28, 32'hA3, 0, 0);
        tick();
        chk("burst_owner3", {30'd0, owner}, 32'd0);
        chk("burst_wait3", 32'(dut.wait0), 32'd3);
        drive1(0, 0, 0, 0, 0);
        expect_acc(0, 0, 32'h14, 0, 1, 32'h55);
        tick();
        chk("burst_wait_clr", 32'(dut.wait0), 32'd0);
        drive0(0, 0, 0, 0, 0);

        // 4: starvation breaks an indefinite lock on the 9th waiting cycle
        drive0(1, 1, 0, 32'h30, 32'hBEEF);
        drive1(1, 0, 1, 32'h20, 0);
        for (int i = 0; i < 8; i++) begin
            expect_acc(1, 0, 32'h20, 0, 1, 32'hA1);
            tick();
        end
        chk("starve_wait_max", 32'(dut.wait0), 32'd8);
        expect_acc(0, 1, 32'h30, 32'hBEEF, 0, 0);
        tick();
        chk("starve_owner", {30'd0, owner}, 32'd0);
        drive0(0, 0, 0, 0, 0);
        expect_acc(1, 0, 32'h20, 0, 1, 32'hA1);
        tick();
        chk("relock_owner", {30'd0, owner}, 32'd2);

        // 6: p0 abandons its request while p1 holds the lock
        drive0(1, 0, 0, 32'h30, 0);
        for (int i = 0; i < 3; i++) begin
            expect_acc(1, 0, 32'h20, 0, 1, 32'hA1);
            tick();
        end
        chk("drop_wait3", 32'(dut.wait0), 32'd3);
        drive0(0, 0, 0, 0, 0);
        expect_acc(1, 0, 32'h20, 0, 1, 32'hA1);
        tick();
        chk("drop_wait_clr", 32'(dut.wait0), 32'd0);
        drive1(0, 0, 0, 0, 0);
        tick();
        chk("release_owner", {30'd0, owner}, 32'd0);

        drive0(1, 0, 0, 32'h30, 0);
        expect_acc(0, 0, 32'h30, 0, 1, 32'hBEEF);
        tick();
        drive0(1, 0, 0, 32'h28, 0);
        expect_acc(0, 0, 32'h28, 0, 1, 32'hA3);
        tick();
        drive0(1, 0, 0, 32'h4C, 0);
        expect_acc(0, 0, 32'h4C, 0, 1, 32'd4);
        tick();
        drive0(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
